ram_prefix_scan: RTL and testbench



---
 rtl/ram_prefix_scan_pkg.sv | 15 +
 rtl/ram_prefix_acc.sv | 24 ++
 rtl/ram_prefix_scan.sv | 99 +++++++++
 tb/tb_ram_prefix_scan.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_prefix_scan_pkg.sv
// Shared state encoding and depth helper for the in-place RAM prefix-sum scanner.
package ram_prefix_scan_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int unsigned last_addr(input int unsigned addr_width);
    return (32'd1 << addr_width) - 32'd1;
  endfunction

endpackage

// File: rtl/ram_prefix_acc.sv
// Running-sum adder and write-data select for the prefix scanner.
// RAM_PREFIX_SCAN_SATURATE_EN clamps written words to all-ones instead of truncating.
module ram_prefix_acc #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic [DATA_WIDTH+ADDR_WIDTH-1:0] acc_i,
  input  logic [DATA_WIDTH-1:0]            q_i,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum_o,
  output logic [DATA_WIDTH-1:0]            data_o
);

  localparam int unsigned AccWidth = DATA_WIDTH + ADDR_WIDTH;

  assign sum_o = acc_i + AccWidth'(q_i);

`ifdef RAM_PREFIX_SCAN_SATURATE_EN
  // Any bit above the word width means the sum no longer fits.
  assign data_o = (|sum_o[AccWidth-1:DATA_WIDTH]) ? '1 : sum_o[DATA_WIDTH-1:0];
`else
  assign data_o = sum_o[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/ram_prefix_scan.sv
// Walks every RAM word and overwrites it in place with the running prefix sum.
// Optional saturation of written words: RAM_PREFIX_SCAN_SATURATE_EN (see ram_prefix_acc).
module ram_prefix_scan
  import ram_prefix_scan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic [ADDR_WIDTH-1:0]           read_addr,
  output logic [ADDR_WIDTH-1:0]           write_addr,
  output logic                            we,
  output logic [DATA_WIDTH-1:0]           data,
  input  logic [DATA_WIDTH-1:0]           q,
  output logic                            busy,
  output logic                            done,
  output logic [DATA_WIDTH+ADDR_WIDTH-1:0] total
);

  localparam int unsigned AccWidth = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(last_addr(ADDR_WIDTH));

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [AccWidth-1:0]   acc_q, acc_d;
  logic [AccWidth-1:0]   total_q, total_d;
  logic [AccWidth-1:0]   sum_n;
  logic [DATA_WIDTH-1:0] sum_data;

  ram_prefix_acc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_acc (
    .acc_i (acc_q),
    .q_i   (q),
    .sum_o (sum_n),
    .data_o(sum_data)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    total_d = total_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      S_READ: state_d = S_WRITE;
      S_WRITE: begin
        acc_d = sum_n;
        // Stop on the last address so idx never wraps inside a scan.
        if (idx_q == LAST_ADDR) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = S_READ;
        end
      end
      S_DONE: begin
        total_d = acc_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      total_q <= total_d;
    end
  end

  // Outputs decode only registered state; reset drops we asynchronously.
  always_comb begin
    read_addr  = idx_q;
    write_addr = idx_q;
    we         = (state_q == S_WRITE);
    busy       = (state_q == S_READ) || (state_q == S_WRITE);
    done       = (state_q == S_DONE);
    data       = (state_q == S_WRITE) ? sum_data : '0;
    total      = total_q;
  end

endmodule

// File: tb/tb_ram_prefix_scan.sv
// Directed bench for ram_prefix_scan with a behavioural registered-read dual-port RAM beside it.
module tb_ram_prefix_scan;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  read_addr, write_addr;
  logic        we;
  logic [7:0]  data, q;
  logic        busy, done;
  logic [11:0] total;

  logic [7:0]  mem [DEPTH];
  logic [7:0]  load_word [DEPTH];
  logic        load;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Read returns old data when the same address is written in the same cycle.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= load_word[i];
    end else if (we) begin
      mem[write_addr] <= data;
    end
    q <= mem[read_addr];
  end

  ram_prefix_scan #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .read_addr (read_addr),
    .write_addr(write_addr),
    .we        (we),
    .data      (data),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .total     (total)
  );

  typedef struct {
    logic [7:0]  fill;
    logic [11:0] exp_total;
    logic [7:0]  exp_w1;
    logic [7:0]  exp_w15;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic preload();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_scan(output int busy_cyc, output bit seen);
    busy_cyc = 0;
    seen     = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  busy_cyc;
    bit  seen;
    int  bad;
    int  dones;
    int  first_done, second_done;
    int  exp_addr;
    logic [11:0] s;
    logic [7:0]  w;

    vecs[0] = '{fill: 8'h01, exp_total: 12'h010, exp_w1: 8'h02, exp_w15: 8'h10};
    vecs[3] = '{fill: 8'h00, exp_total: 12'h000, exp_w1: 8'h00, exp_w15: 8'h00};
`ifdef RAM_PREFIX_SCAN_SATURATE_EN
    vecs[1] = '{fill: 8'hFF, exp_total: 12'hFF0, exp_w1: 8'hFF, exp_w15: 8'hFF};
    vecs[2] = '{fill: 8'h10, exp_total: 12'h100, exp_w1: 8'h20, exp_w15: 8'hFF};
`else
    vecs[1] = '{fill: 8'hFF, exp_total: 12'hFF0, exp_w1: 8'hFE, exp_w15: 8'hF0};
    vecs[2] = '{fill: 8'h10, exp_total: 12'h100, exp_w1: 8'h20, exp_w15: 8'h00};
`endif

    rst   = 1'b1;
    start = 1'b0;
    load  = 1'b0;
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_we", we, 0);
    check("reset_read_addr", read_addr, 0);
    check("reset_write_addr", write_addr, 0);
    check("reset_data", data, 0);
    check("reset_total", total, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < DEPTH; i++) load_word[i] = vecs[v].fill;
      preload();
      run_scan(busy_cyc, seen);
      check($sformatf("v%0d_done_seen", v), 32'(seen), 1);
      check($sformatf("v%0d_busy_cycles", v), busy_cyc, 32);
      @(negedge clk);
      check($sformatf("v%0d_done_one_cycle", v), done, 0);
      check($sformatf("v%0d_total", v), total, vecs[v].exp_total);
      check($sformatf("v%0d_word1", v), mem[1], vecs[v].exp_w1);
      check($sformatf("v%0d_word15", v), mem[15], vecs[v].exp_w15);
      bad = 0;
      s   = '0;
      for (int i = 0; i < DEPTH; i++) begin
        s = s + 12'(vecs[v].fill);
`ifdef RAM_PREFIX_SCAN_SATURATE_EN
        w = (s > 12'h0FF) ? 8'hFF : s[7:0];
`else
        w = s[7:0];
`endif
        if (mem[i] !== w) bad++;
      end
      check($sformatf("v%0d_all_words", v), bad, 0);
    end

    // Reset in the middle of the scan, while writing word 5.
    for (int i = 0; i < DEPTH; i++) load_word[i] = 8'h01;
    preload();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (we && write_addr == 4'd5) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rst_reached_idx5", 32'(seen), 1);
    rst = 1'b1;
    #1;
    check("rst_we_async", we, 0);
    check("rst_busy", busy, 0);
    check("rst_total", total, 0);
    @(negedge clk);
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("rst_no_done", dones, 0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ((i < 5) ? 8'(i + 1) : 8'h01)) bad++;
    end
    check("rst_words", bad, 0);

    // start held high: back-to-back scans every 34 cycles.
    for (int i = 0; i < DEPTH; i++) load_word[i] = 8'h00;
    preload();
    start       = 1'b1;
    dones       = 0;
    bad         = 0;
    first_done  = 0;
    second_done = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        dones++;
        if (dones == 1) first_done = k;
        if (dones == 2) second_done = k;
        if (busy) bad++;
      end
    end
    start = 1'b0;
    check("held_done_count", dones, 2);
    check("held_first_done", first_done, 33);
    check("held_done_spacing", second_done - first_done, 34);
    check("held_busy_in_done", bad, 0);
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_last_done", 32'(seen), 1);
    @(negedge clk);
    check("held_idle_busy", busy, 0);
    check("held_total", total, 0);

    // start pulsed while busy must not restart the scan.
    for (int i = 0; i < DEPTH; i++) load_word[i] = 8'(i + 1);
    preload();
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dones    = 0;
    bad      = 0;
    exp_addr = 0;
    for (int k = 1; k <= 40; k++) begin
      if (we) begin
        if (write_addr != 4'(exp_addr)) bad++;
        exp_addr++;
      end
      if (done) dones++;
      start = (k < 30) && (k % 7 == 3);
      @(negedge clk);
    end
    start = 1'b0;
    check("pulse_addr_order", bad, 0);
    check("pulse_write_count", exp_addr, 16);
    check("pulse_done_count", dones, 1);
    check("pulse_idle", busy, 0);
    check("pulse_total", total, 12'd136);
    bad = 0;
    s   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      s = s + 12'(i + 1);
      if (mem[i] !== s[7:0]) bad++;
    end
    check("pulse_words", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
